// File: rtl/ad9637_spi_ctrl.sv
// ad9637_spi_ctrl
// SPI master sequencer for the AD9637 3-wire configuration port.
// Accepts one register-access command, builds the 24-bit frame
// {R/W, W1:W0=00, addr[12:0], data[7:0]}, shifts it out MSB first,
// turns SDIO around for reads, and returns the read byte with a done pulse.
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_rw/addr/wdata      command fields, sampled at accept only
//   done                   one-cycle completion pulse
//   rsp_rdata              last read byte, held until the next read completes
//   busy                   frame in progress (cycle after accept .. end of GAP)
//   spi_sclk/csb           serial clock (idles low) and chip select (active low)
//   spi_sdio_o/oe/i        bidirectional SDIO split into out, enable, in
module ad9637_spi_ctrl #(
  parameter int CLK_DIV = 4  // ACLK cycles per SCLK half-period, 2..255
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        done,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_csb,
  output logic        spi_sdio_o,
  output logic        spi_sdio_oe,
  input  logic        spi_sdio_i
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;          // cycle counter within a phase
  logic [4:0]  bit_q, bit_d;          // current bit index k, 23..0
  logic        phase_lo_q, phase_lo_d; // 0 = sclk high half, 1 = sclk low half
  logic [23:0] frame_q, frame_d;
  logic [7:0]  rd_sh_q, rd_sh_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;

  logic accept;
  logic is_rd;

  assign accept = cmd_valid && (state_q == IDLE);
  assign is_rd  = frame_q[23];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_lo_q <= 1'b0;
      frame_q    <= '0;
      rd_sh_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      phase_lo_q <= phase_lo_d;
      frame_q    <= frame_d;
      rd_sh_q    <= rd_sh_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    phase_lo_d = phase_lo_q;
    frame_d    = frame_q;
    rd_sh_d    = rd_sh_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = {cmd_rw, 2'b00, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};
          cnt_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_d      = 5'd23;
          phase_lo_d = 1'b0;
          state_d    = SHIFT;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!phase_lo_q) begin
            // This edge drives sclk 1->0: capture read data for bits 7..0.
            phase_lo_d = 1'b1;
            if (bit_q < 5'd8) begin
              rd_sh_d = {rd_sh_q[6:0], spi_sdio_i};
            end
          end else if (bit_q == 5'd0) begin
            state_d = GAP;
          end else begin
            bit_d      = bit_q - 5'd1;
            phase_lo_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_rd) begin
            rdata_d = rd_sh_q;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pin outputs decode purely from async-reset registers, so a reset
  // forces them idle without needing a clock edge.
  always_comb begin
    spi_csb     = 1'b1;
    spi_sclk    = 1'b0;
    spi_sdio_o  = 1'b0;
    spi_sdio_oe = 1'b0;
    case (state_q)
      SETUP: begin
        spi_csb     = 1'b0;
        spi_sdio_o  = frame_q[23];
        spi_sdio_oe = 1'b1;
      end
      SHIFT: begin
        spi_csb  = 1'b0;
        spi_sclk = !phase_lo_q;
        // In the low half of bit k the next bit k-1 is already presented,
        // so data only moves on the falling edge.
        if (phase_lo_q && (bit_q != 5'd0)) begin
          spi_sdio_o = frame_q[bit_q - 5'd1];
        end else begin
          spi_sdio_o = frame_q[bit_q];
        end
        // Reads release SDIO from the falling edge that ends bit 8 onward.
        spi_sdio_oe = !(is_rd && ((bit_q < 5'd8) || ((bit_q == 5'd8) && phase_lo_q)));
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: doc/ad9637_spi_ctrl.md
# ad9637_spi_ctrl

SPI master sequencer for the AD9637 ADC's 3-wire configuration port (SCLK, CSB, bidirectional SDIO). It sits behind the AD_9637_SPI AXI4-Lite register bank. It accepts one register-access command at a time, builds the 24-bit AD9637 frame (16-bit instruction plus one data byte), shifts it out MSB first, turns SDIO around for reads, and returns the read byte with a completion pulse.

## Interface
Parameters:
- CLK_DIV, 4, ACLK cycles per SCLK half-period (H); legal range 2..255; SCLK = ACLK/(2·H)

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  13  AD9637 register address
- cmd_wdata  in  8  write byte (ignored for reads)
- done  out  1  one-cycle pulse when a frame completes (read and write)
- rsp_rdata  out  8  last read byte; valid from done, held until the next read completes
- busy  out  1  high from the cycle after accept through the end of GAP
- spi_sclk  out  1  serial clock, idles low
- spi_csb  out  1  chip select, active low
- spi_sdio_o  out  1  SDIO output data
- spi_sdio_oe  out  1  SDIO output enable (1 = master drives)
- spi_sdio_i  in  1  SDIO input data (from the pad, already synchronous to ACLK)

## Operation
- Reset values: cmd_ready=1, busy=0, done=0, rsp_rdata=0x00, spi_sclk=0, spi_csb=1, spi_sdio_o=0, spi_sdio_oe=0; state IDLE.
- Frame word F[23:0], latched at accept:
  - F[23] = cmd_rw.
  - F[22:21] = 2'b00 (W1:W0, one byte).
  - F[20:8] = cmd_addr.
  - F[7:0] = cmd_wdata for writes, 0 for reads.
- Command inputs are sampled only at accept; later changes have no effect.
- States: IDLE → SETUP → SHIFT → GAP → IDLE.
- IDLE: cmd_ready=1. On accept, go to SETUP next cycle.
- SETUP (H cycles): csb=0, sclk=0, oe=1, sdio_o=F[23].
- SHIFT: 24 bit periods, index k = 23..0. Each period is H cycles with sclk=1, then H cycles with sclk=0.
  - sdio_o changes only on the cycle sclk goes 1→0, to F[k-1]. The slave samples on the rising edge.
  - Read turnaround: on the falling edge that ends bit 8 (the last address bit), oe→0 and stays 0 for bits 7..0.
  - Read sampling: spi_sdio_i is sampled on the ACLK edge that drives sclk 1→0, for bits 7..0, into a shift register MSB first.
  - Writes keep oe=1 for all 24 bits.
- GAP (2H cycles): entered after the low phase of bit 0. csb=1, oe=0, sclk=0, sdio_o=0.
- Completion, on the cycle IDLE is re-entered:
  - done=1 for one cycle.
  - Read: rsp_rdata ← captured byte.
  - Write: rsp_rdata unchanged.
- ARESETN low at any time: all outputs return to reset values immediately (asynchronously), the frame is discarded and no done pulse is issued.

## Timing
- Accept at edge T0.
- busy=1 and cmd_ready=0 over cycles T0+1 .. T0+51H.
- done=1 and cmd_ready=1 at cycle T0+51H+1.
- Examples: CLK_DIV=4 gives 204 busy cycles; CLK_DIV=2 gives 102.
- CSB low to first SCLK rise: H cycles.
- Last SCLK fall to CSB rise: H cycles.
- Minimum CSB-high time between frames: 2H+1 cycles. A command presented with done is accepted on that same cycle (back-to-back).
- SCLK duty cycle is exactly 50 %. No SCLK edges occur while csb=1.
- Read data latency: the byte is visible on rsp_rdata in the done cycle.

## Test plan
- Write, CLK_DIV=4, cmd_addr=0x014, cmd_wdata=0x01 → slave model captures 0x001401 on 24 rising edges, MSB first. oe=1 throughout. busy for exactly 204 cycles. One done pulse. rsp_rdata unchanged.
- Read, cmd_addr=0x001, slave drives 0x91 after the 16th falling edge → instruction captured as 0x8001. oe=0 exactly for bits 7..0. rsp_rdata=0x91 at done.
- Back-to-back: cmd_valid held high for a write to 0x0FF then a read of 0x008 → second accept coincides with the first done. CSB high for 2H+1 cycles between frames. Two done pulses.
- Busy rejection: cmd_valid pulsed and cmd_addr changed mid-frame → cmd_ready stays 0. The in-flight frame is unaffected. No extra frame is issued.
- Reset mid-frame: ARESETN asserted during bit 10 → csb=1, sclk=0, oe=0 with no clock edge needed. No done pulse. A read after reset runs a complete 51H-cycle frame.
- CLK_DIV=2, read with slave returning 0xA5 → busy for 102 cycles. sclk high/low 2 cycles each. rsp_rdata=0xA5.
